i2c_slave_rx_tx: RTL

I2C slave endpoint that sits directly downstream of the I2C master controller on the same SCL/SDA wires. It consumes the master's START, address and R/W phases and answers with ACK/NACK. It also receives write bytes into a local parallel interface and serves read bytes from it. Bus lines are oversampled on the system clock; the block never drives SCL (no clock stretching).

---
 rtl/i2c_slave_rx_tx.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_rx_tx.sv
// I2C slave endpoint: oversampled SCL/SDA, address match with ACK/NACK,
// byte receive into RxData and byte transmit from TxData. Never drives SCL.
module i2c_slave_rx_tx #(
  parameter int                       ADDRESSLENGTH = 7,
  parameter logic [ADDRESSLENGTH-1:0] SLAVE_ADDRESS = 7'h50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SDA_oe,
  output logic [7:0] RxData,
  output logic       RxValid,
  input  logic       RxReady,
  input  logic [7:0] TxData,
  output logic       TxReq,
  output logic       Busy,
  output logic       RorW
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_DATA,
    RX_ACK,
    TX_DATA,
    TX_ACK,
    WAIT_STOP
  } state_t;

  localparam logic [3:0] ADDR_BITS = 4'(ADDRESSLENGTH);
  localparam logic [3:0] ADDR_LAST = 4'(ADDRESSLENGTH + 1);

  // Input conditioning: two sync stages plus one history stage per line.
  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge value of its neighbours.
    if (RST) begin
      {scl_s1, scl_s2, scl_h} <= 3'b111;
      {sda_s1, sda_s2, sda_h} <= 3'b111;
    end else begin
      scl_s1 <= SCL_in;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= SDA_in;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c;

  assign scl_rise = scl_s2 & ~scl_h;
  assign scl_fall = ~scl_s2 & scl_h;
  assign start_c  = scl_s2 & sda_h & ~sda_s2;
  assign stop_c   = scl_s2 & ~sda_h & sda_s2;

  // Protocol state and datapath registers.
  state_t                   state, state_n;
  logic [3:0]               bit_cnt, bit_cnt_n;
  logic [ADDRESSLENGTH-1:0] addr_sr, addr_sr_n;
  logic [7:0]               rx_sr, rx_sr_n;
  logic [7:0]               tx_sr, tx_sr_n;
  logic                     mack, mack_n;
  logic                     sda_oe_q, sda_oe_n;
  logic [7:0]               rx_data_q, rx_data_n;
  logic                     rx_valid_q, rx_valid_n;
  logic                     tx_req_q, tx_req_n;
  logic                     busy_q, busy_n;
  logic                     rorw_q, rorw_n;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      addr_sr    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      mack       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      rorw_q     <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      addr_sr    <= addr_sr_n;
      rx_sr      <= rx_sr_n;
      tx_sr      <= tx_sr_n;
      mack       <= mack_n;
      sda_oe_q   <= sda_oe_n;
      rx_data_q  <= rx_data_n;
      rx_valid_q <= rx_valid_n;
      tx_req_q   <= tx_req_n;
      busy_q     <= busy_n;
      rorw_q     <= rorw_n;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold/default value first so no path
    // through the case below can infer a latch.
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    addr_sr_n  = addr_sr;
    rx_sr_n    = rx_sr;
    tx_sr_n    = tx_sr;
    mack_n     = mack;
    sda_oe_n   = sda_oe_q;
    rx_data_n  = rx_data_q;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    busy_n     = busy_q;
    rorw_n     = rorw_q;

    // A byte completing in the same cycle as STOP is still delivered.
    if (state == RX_DATA && scl_rise && bit_cnt == 4'd7 && !start_c) begin
      rx_data_n  = {rx_sr[6:0], sda_s2};
      rx_valid_n = 1'b1;
    end

    if (start_c) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (stop_c) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;

        ADDR: begin
          if (bit_cnt == ADDR_LAST) begin
            if (scl_fall) begin
              sda_oe_n  = 1'b1;
              busy_n    = 1'b1;
              bit_cnt_n = '0;
              state_n   = ADDR_ACK;
            end
          end else if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt < ADDR_BITS) begin
              addr_sr_n = {addr_sr[ADDRESSLENGTH-2:0], sda_s2};
            end else if (addr_sr == SLAVE_ADDRESS) begin
              rorw_n = sda_s2;
            end else begin
              bit_cnt_n = '0;
              state_n   = WAIT_STOP;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = '0;
            if (rorw_q) begin
              tx_sr_n  = TxData;
              tx_req_n = 1'b1;
              sda_oe_n = ~TxData[7];
              state_n  = TX_DATA;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = RX_DATA;
            end
          end
        end

        RX_DATA: begin
          if (bit_cnt == 4'd8) begin
            if (scl_fall) begin
              sda_oe_n  = RxReady;
              bit_cnt_n = '0;
              state_n   = RX_ACK;
            end
          end else if (scl_rise) begin
            rx_sr_n   = {rx_sr[6:0], sda_s2};
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end

        RX_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = RX_DATA;
          end
        end

        TX_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd7) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              mack_n    = 1'b0;
              state_n   = TX_ACK;
            end else begin
              tx_sr_n   = {tx_sr[6:0], 1'b0};
              sda_oe_n  = ~tx_sr[6];
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end

        TX_ACK: begin
          if (scl_rise) begin
            if (sda_s2) state_n = WAIT_STOP;
            else        mack_n  = 1'b1;
          end else if (scl_fall && mack) begin
            mack_n   = 1'b0;
            tx_sr_n  = TxData;
            tx_req_n = 1'b1;
            sda_oe_n = ~TxData[7];
            state_n  = TX_DATA;
          end
        end

        WAIT_STOP: sda_oe_n = 1'b0;

        default: state_n = IDLE;
      endcase
    end
  end

  assign SDA_oe  = sda_oe_q;
  assign RxData  = rx_data_q;
  assign RxValid = rx_valid_q;
  assign TxReq   = tx_req_q;
  assign Busy    = busy_q;
  assign RorW    = rorw_q;

endmodule
